// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types, constants and helpers for the seq_divider block.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int DIV_W_DEFAULT = 32;
  localparam int DIV_W_MAX     = 64;

  // Operates on a sign-extended DIV_W_MAX-bit value; callers truncate to their width.
  function automatic logic [DIV_W_MAX-1:0] abs_val(input logic [DIV_W_MAX-1:0] value,
                                                    input logic                 signed_flag);
    return (signed_flag && value[DIV_W_MAX-1]) ? -value : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_if
// Purpose  : Start/operand request and result bundle of the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W_DEFAULT
);
  logic              i_start;
  logic              i_signed;
  logic [DATA_W-1:0] i_dividend;
  logic [DATA_W-1:0] i_divisor;
  logic              o_busy;
  logic              o_valid;
  logic [DATA_W-1:0] o_quotient;
  logic [DATA_W-1:0] o_remainder;
  logic              o_div_by_zero;

  modport master (
    output i_start, i_signed, i_dividend, i_divisor,
    input  o_busy, o_valid, o_quotient, o_remainder, o_div_by_zero
  );

  modport slave (
    input  i_start, i_signed, i_dividend, i_divisor,
    output o_busy, o_valid, o_quotient, o_remainder, o_div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational shift-subtract-restore step of the divider.
// Revision : 1.0 - initial release
// ============================================================================
module div_step
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W_DEFAULT
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_qbit
);

  logic [DATA_W:0] w_trial;

  assign w_trial = {i_rem, i_bit} - {1'b0, i_divisor};

  // A set remainder MSB means the shifted value exceeds any divisor, even if the
  // DATA_W+1-bit difference wraps; its low DATA_W bits are still exact.
  assign o_qbit = i_rem[DATA_W-1] | ~w_trial[DATA_W];
  assign o_rem  = o_qbit ? w_trial[DATA_W-1:0] : {i_rem[DATA_W-2:0], i_bit};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient
//            bit per cycle. Optional: SEQ_DIV_EARLY_OUT_EN skips CALC when
//            |divisor| > |dividend|.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  seq_divider_if.slave bus
);

  localparam int                     c_cnt_w    = $clog2(DATA_W);
  localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(DATA_W - 1);
  localparam logic [DIV_W_MAX-1:0]   c_ext_mask = ~DIV_W_MAX'({DATA_W{1'b1}});

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dbz_q, dbz_d;
  logic [DATA_W-1:0] quo_out_q, quo_out_d;
  logic [DATA_W-1:0] rem_out_q, rem_out_d;
  logic              dbz_out_q, dbz_out_d;

  logic                 w_dvd_neg;
  logic                 w_dsr_neg;
  logic [DIV_W_MAX-1:0] w_dvd_ext;
  logic [DIV_W_MAX-1:0] w_dsr_ext;
  logic [DATA_W-1:0]    w_dvd_mag;
  logic [DATA_W-1:0]    w_dsr_mag;
  logic                 w_dsr_zero;
  logic [DATA_W-1:0]    w_step_rem;
  logic                 w_step_qbit;

  assign w_dvd_neg  = bus.i_signed & bus.i_dividend[DATA_W-1];
  assign w_dsr_neg  = bus.i_signed & bus.i_divisor[DATA_W-1];
  assign w_dvd_ext  = DIV_W_MAX'(bus.i_dividend) | (w_dvd_neg ? c_ext_mask : '0);
  assign w_dsr_ext  = DIV_W_MAX'(bus.i_divisor)  | (w_dsr_neg ? c_ext_mask : '0);
  assign w_dvd_mag  = DATA_W'(abs_val(w_dvd_ext, bus.i_signed));
  assign w_dsr_mag  = DATA_W'(abs_val(w_dsr_ext, bus.i_signed));
  assign w_dsr_zero = (bus.i_divisor == '0);

  div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .i_rem     (rem_q),
    .i_bit     (dvd_q[DATA_W-1]),
    .i_divisor (dsr_q),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_qbit)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    dbz_out_d = dbz_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          dvd_d     = w_dvd_mag;
          dsr_d     = w_dsr_mag;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = w_dvd_neg ^ w_dsr_neg;
          neg_rem_d = w_dvd_neg;
          dbz_d     = w_dsr_zero;
          // Shortcut paths park |dividend| in rem so FIX's sign fix-up restores it.
          if (w_dsr_zero) begin
            rem_d   = w_dvd_mag;
            state_d = FIX;
          end
`ifdef SEQ_DIV_EARLY_OUT_EN
          else if (w_dsr_mag > w_dvd_mag) begin
            rem_d   = w_dvd_mag;
            dvd_d   = '0;
            state_d = FIX;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = w_step_rem;
        dvd_d = {dvd_q[DATA_W-2:0], w_step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_cnt_last) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quo_out_d = dbz_q ? {DATA_W{1'b1}} : (neg_quo_q ? -dvd_q : dvd_q);
        rem_out_d = neg_rem_q ? -rem_q : rem_q;
        dbz_out_d = dbz_q;
        state_d   = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.o_busy        = (state_q == CALC) || (state_q == FIX);
  assign bus.o_valid       = (state_q == DONE);
  assign bus.o_quotient    = quo_out_q;
  assign bus.o_remainder   = rem_out_q;
  assign bus.o_div_by_zero = dbz_out_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Directed self-checking bench for seq_divider (32-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int LAT_FULL = 34;
  localparam int LAT_DBZ  = 2;
`ifdef SEQ_DIV_EARLY_OUT_EN
  localparam int LAT_SMALL = 2;
`else
  localparam int LAT_SMALL = 34;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.DATA_W(32)) bus ();

  seq_divider #(
    .DATA_W (32)
  ) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int elat);
    int   n;
    logic busy_ok;
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_signed   = sgn;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    n       = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (!bus.o_valid && !bus.o_busy) busy_ok = 1'b0;
    end while (!bus.o_valid && n < 100);
    check_eq({tag, "_lat"}, n, elat);
    check_eq({tag, "_quo"}, bus.o_quotient, eq);
    check_eq({tag, "_rem"}, bus.o_remainder, er);
    check_eq({tag, "_dbz"}, {31'b0, bus.o_div_by_zero}, {31'b0, edbz});
    check_eq({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_pulse"}, {31'b0, bus.o_valid}, 32'd0);
    check_eq({tag, "_hold"}, bus.o_quotient, eq);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nv;
    int          first_cyc;
    int          second_cyc;
    logic [31:0] q1, r1, q2, r2;

    bus.i_start    = 1'b0;
    bus.i_signed   = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",  {31'b0, bus.o_busy}, 32'd0);
    check_eq("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    check_eq("rst_quo",   bus.o_quotient, 32'd0);
    check_eq("rst_rem",   bus.o_remainder, 32'd0);
    check_eq("rst_dbz",   {31'b0, bus.o_div_by_zero}, 32'd0);
    rst = 1'b0;

    run_op("u100_7",    1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        1'b0, LAT_FULL);
    run_op("s-7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT_FULL);
    run_op("s7_-2",     1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, LAT_FULL);
    run_op("s-100_-7",  1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 1'b0, LAT_FULL);
    run_op("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0, LAT_FULL);
    run_op("u_max_1",   1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, LAT_FULL);
    run_op("u_bigdsr",  1'b0, 32'hFFFF_FFFF,  32'h8000_0001, 32'd1,        32'h7FFF_FFFE, 1'b0, LAT_FULL);
    run_op("u_small",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, LAT_SMALL);
    run_op("u5_9",      1'b0, 32'd5,          32'd9,        32'd0,         32'd5,        1'b0, LAT_SMALL);
    run_op("u_dbz",     1'b0, 32'h1234,       32'd0,        32'hFFFF_FFFF, 32'h1234,     1'b1, LAT_DBZ);
    run_op("s_dbz",     1'b1, 32'h1234,       32'd0,        32'hFFFF_FFFF, 32'h1234,     1'b1, LAT_DBZ);

    // Abort during CALC iteration 10
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_signed   = 1'b0;
    bus.i_dividend = 32'd1000;
    bus.i_divisor  = 32'd3;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort_busy_pre", {31'b0, bus.o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy",  {31'b0, bus.o_busy}, 32'd0);
    check_eq("abort_valid", {31'b0, bus.o_valid}, 32'd0);
    check_eq("abort_quo",   bus.o_quotient, 32'd0);
    check_eq("abort_rem",   bus.o_remainder, 32'd0);
    check_eq("abort_dbz",   {31'b0, bus.o_div_by_zero}, 32'd0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) nv++;
    end
    check_eq("abort_novalid", nv, 32'd0);

    // Start held high: second operands only taken in IDLE after DONE
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_signed   = 1'b0;
    bus.i_dividend = 32'd100;
    bus.i_divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.i_dividend = 32'd50;
    bus.i_divisor  = 32'd5;
    nv = 0; first_cyc = 0; second_cyc = 0;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int c = 1; c <= 69; c++) begin
      @(negedge clk);
      if (bus.o_valid) begin
        nv++;
        if (nv == 1) begin first_cyc = c; q1 = bus.o_quotient; r1 = bus.o_remainder; end
        else begin second_cyc = c; q2 = bus.o_quotient; r2 = bus.o_remainder; end
      end
    end
    bus.i_start = 1'b0;
    check_eq("held_nvalid", nv, 32'd2);
    check_eq("held_first",  first_cyc, 32'd34);
    check_eq("held_second", second_cyc, 32'd69);
    check_eq("held_q1", q1, 32'd14);
    check_eq("held_r1", r1, 32'd2);
    check_eq("held_q2", q2, 32'd10);
    check_eq("held_r2", r2, 32'd0);
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.o_valid) nv++;
    end
    check_eq("held_after", nv, 32'd0);

    run_op("u_recover", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, LAT_FULL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
